// File: rtl/echo_avg_filter.sv
// Moving average of good echo measurements with error counting, stale flag and fx byte readout.
// avg_data/avg_vld appear two cycles after an accepted sample; no backpressure; ECHO_MINMAX_EN adds min/max registers.
module echo_avg_filter #(
  parameter int          DW        = 16,
  parameter int          AVG_LOG2  = 3,
  parameter int          ERR_LIMIT = 4,
  parameter logic [21:0] BASE_ADDR = 22'h000100
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          done_measure,
  input  logic          err_measure,
  input  logic [DW-1:0] data_measure,
  output logic [DW-1:0] avg_data,
  output logic          avg_vld,
  output logic          stale,
  output logic [7:0]    err_cnt,
  input  logic          fx_rd,
  input  logic [21:0]   fx_raddr,
  output logic [7:0]    fx_q
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DW + AVG_LOG2;
  localparam int CW    = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_STALE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2-1:0] wptr_q, wptr_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [CW-1:0]       consec_q, consec_d;
  logic                stale_q, stale_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                upd_q, upd_d;
  logic [DW-1:0]       avg_data_q, avg_data_d;
  logic                avg_vld_q, avg_vld_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          fx_dat_q, fx_dat_d;
  logic [DW-1:0]       ring_q [DEPTH];

  logic        acc, errv, flush;
  logic [15:0] avg16;
  logic [21:0] off;

  assign acc   = done_measure & ~err_measure;
  assign errv  = done_measure & err_measure;
  assign flush = errv & (consec_q == CW'(ERR_LIMIT - 1));
  assign avg16 = 16'(avg_data_q);
  assign off   = fx_raddr - BASE_ADDR;

`ifdef ECHO_MINMAX_EN
  logic [DW-1:0] min_q, min_d, max_q, max_d;
  logic [7:0]    min_sh_q, min_sh_d, max_sh_q, max_sh_d;
  logic [15:0]   min16, max16;
  assign min16 = 16'(min_q);
  assign max16 = 16'(max_q);
`endif

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    consec_d   = consec_q;
    stale_d    = stale_q;
    err_cnt_d  = err_cnt_q;
    upd_d      = 1'b0;
    avg_vld_d  = upd_q;
    avg_data_d = avg_data_q;
    shadow_d   = shadow_q;
    fx_dat_d   = fx_dat_q;
`ifdef ECHO_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
    min_sh_d   = min_sh_q;
    max_sh_d   = max_sh_q;
`endif

    // sum_q here already includes the sample accepted in the previous cycle
    if (upd_q) avg_data_d = sum_q[SW-1:AVG_LOG2];

    if (acc) begin
      consec_d = '0;
      stale_d  = 1'b0;
      wptr_d   = wptr_q + 1'b1;
      if (state_q == ST_RUN) begin
        sum_d = sum_q - SW'(ring_q[wptr_q]) + SW'(data_measure);
        upd_d = 1'b1;
      end else begin
        sum_d   = sum_q + SW'(data_measure);
        fill_d  = fill_q + 1'b1;
        state_d = ST_FILL;
        if (fill_q == (AVG_LOG2 + 1)'(DEPTH - 1)) begin
          state_d = ST_RUN;
          upd_d   = 1'b1;
        end
      end
`ifdef ECHO_MINMAX_EN
      if (data_measure < min_q) min_d = data_measure;
      if (data_measure > max_q) max_d = data_measure;
`endif
    end else if (errv) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (consec_q < CW'(ERR_LIMIT)) consec_d = consec_q + 1'b1;
      if (flush) begin
        state_d = ST_STALE;
        stale_d = 1'b1;
        sum_d   = '0;
        fill_d  = '0;
        wptr_d  = '0;
`ifdef ECHO_MINMAX_EN
        min_d   = '1;
        max_d   = '0;
`endif
      end
    end

    if (fx_rd) begin
      case (off)
        22'd0: begin
          fx_dat_d = avg16[7:0];
          shadow_d = avg16[15:8];
        end
        22'd1:   fx_dat_d = shadow_q;
        22'd2:   fx_dat_d = err_cnt_q;
        22'd3:   fx_dat_d = {6'b0, stale_q, state_q == ST_RUN};
`ifdef ECHO_MINMAX_EN
        22'd4: begin
          fx_dat_d = min16[7:0];
          min_sh_d = min16[15:8];
        end
        22'd5:   fx_dat_d = min_sh_q;
        22'd6: begin
          fx_dat_d = max16[7:0];
          max_sh_d = max16[15:8];
        end
        22'd7:   fx_dat_d = max_sh_q;
`endif
        default: fx_dat_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      sum_q      <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
      consec_q   <= '0;
      stale_q    <= 1'b0;
      err_cnt_q  <= '0;
      upd_q      <= 1'b0;
      avg_data_q <= '0;
      avg_vld_q  <= 1'b0;
      shadow_q   <= '0;
      fx_dat_q   <= '0;
`ifdef ECHO_MINMAX_EN
      min_q      <= '1;
      max_q      <= '0;
      min_sh_q   <= '0;
      max_sh_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      consec_q   <= consec_d;
      stale_q    <= stale_d;
      err_cnt_q  <= err_cnt_d;
      upd_q      <= upd_d;
      avg_data_q <= avg_data_d;
      avg_vld_q  <= avg_vld_d;
      shadow_q   <= shadow_d;
      fx_dat_q   <= fx_dat_d;
`ifdef ECHO_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
      min_sh_q   <= min_sh_d;
      max_sh_q   <= max_sh_d;
`endif
    end
  end

  // Window storage is never cleared: FILL only adds, so stale entries are never read
  always_ff @(posedge clk_sys) begin
    if (acc) ring_q[wptr_q] <= data_measure;
  end

  assign avg_data = avg_data_q;
  assign avg_vld  = avg_vld_q;
  assign stale    = stale_q;
  assign err_cnt  = err_cnt_q;
  assign fx_q     = fx_dat_q;

endmodule

// File: tb/tb_echo_avg_filter.sv
// Directed bench for echo_avg_filter: fill/run averaging, stale flush, fx register reads, reset.
module tb_echo_avg_filter;
  localparam logic [21:0] BASE = 22'h000100;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        done_measure = 1'b0;
  logic        err_measure = 1'b0;
  logic [15:0] data_measure = '0;
  logic [15:0] avg_data;
  logic        avg_vld;
  logic        stale;
  logic [7:0]  err_cnt;
  logic        fx_rd = 1'b0;
  logic [21:0] fx_raddr = '0;
  logic [7:0]  fx_q;

  int n_chk = 0;
  int n_fail = 0;
  int vld_total = 0;

  echo_avg_filter dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .done_measure(done_measure), .err_measure(err_measure), .data_measure(data_measure),
    .avg_data(avg_data), .avg_vld(avg_vld), .stale(stale), .err_cnt(err_cnt),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (avg_vld) vld_total++;

  task automatic send(input logic [15:0] d);
    done_measure = 1'b1; err_measure = 1'b0; data_measure = d;
    @(posedge clk_sys); #1;
    done_measure = 1'b0;
  endtask

  task automatic send_err();
    done_measure = 1'b1; err_measure = 1'b1;
    @(posedge clk_sys); #1;
    done_measure = 1'b0; err_measure = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic rd(input logic [21:0] a, output logic [7:0] q);
    fx_rd = 1'b1; fx_raddr = a;
    @(posedge clk_sys); #1;
    fx_rd = 1'b0;
    q = fx_q;
  endtask

  task automatic test_reset();
    n_chk++; if (avg_data !== 16'd0) begin n_fail++; $display("FAIL reset_avg: got %0d want 0", avg_data); end
    n_chk++; if (avg_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", avg_vld); end
    n_chk++; if (stale !== 1'b0) begin n_fail++; $display("FAIL reset_stale: got %b want 0", stale); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    n_chk++; if (fx_q !== 8'd0) begin n_fail++; $display("FAIL reset_fxq: got %h want 00", fx_q); end
  endtask

  task automatic test_fill();
    int base;
    logic [7:0] q;
    base = vld_total;
    repeat (8) send(16'd100);
    n_chk++; if (avg_vld !== 1'b0) begin n_fail++; $display("FAIL fill_early_vld: got %b want 0", avg_vld); end
    idle(1);
    n_chk++; if (avg_vld !== 1'b1) begin n_fail++; $display("FAIL fill_vld: got %b want 1", avg_vld); end
    n_chk++; if (avg_data !== 16'd100) begin n_fail++; $display("FAIL fill_avg: got %0d want 100", avg_data); end
    idle(1);
    n_chk++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL fill_vld_count: got %0d want 1", vld_total - base); end
    rd(BASE + 22'd3, q);
    n_chk++; if (q !== 8'h01) begin n_fail++; $display("FAIL fill_status: got %h want 01", q); end
  endtask

  task automatic test_run();
    int base;
    base = vld_total;
    send(16'd180);
    idle(1);
    n_chk++; if (avg_vld !== 1'b1) begin n_fail++; $display("FAIL run_vld: got %b want 1", avg_vld); end
    n_chk++; if (avg_data !== 16'd110) begin n_fail++; $display("FAIL run_avg: got %0d want 110", avg_data); end
    repeat (8) send(16'd100);
    idle(2);
    n_chk++; if (avg_data !== 16'd100) begin n_fail++; $display("FAIL run_recover: got %0d want 100", avg_data); end
    n_chk++; if (vld_total - base !== 9) begin n_fail++; $display("FAIL run_vld_count: got %0d want 9", vld_total - base); end
  endtask

  task automatic test_stale();
    int base;
    logic [7:0] q;
    repeat (4) send_err();
    n_chk++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_set: got %b want 1", stale); end
    n_chk++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL stale_errcnt: got %0d want 4", err_cnt); end
    n_chk++; if (avg_data !== 16'd100) begin n_fail++; $display("FAIL stale_hold: got %0d want 100", avg_data); end
    rd(BASE + 22'd3, q);
    n_chk++; if (q !== 8'h02) begin n_fail++; $display("FAIL stale_status: got %h want 02", q); end
    base = vld_total;
    send(16'd50);
    n_chk++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear: got %b want 0", stale); end
    repeat (6) send(16'd50);
    idle(3);
    n_chk++; if (vld_total - base !== 0) begin n_fail++; $display("FAIL refill_no_vld: got %0d want 0", vld_total - base); end
    send(16'd50);
    idle(2);
    n_chk++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL refill_vld: got %0d want 1", vld_total - base); end
    n_chk++; if (avg_data !== 16'd50) begin n_fail++; $display("FAIL refill_avg: got %0d want 50", avg_data); end
  endtask

  task automatic test_coherent();
    logic [7:0] q;
    repeat (8) send(16'h1234);
    idle(2);
    rd(BASE, q);
    n_chk++; if (q !== 8'h34) begin n_fail++; $display("FAIL coh_lo: got %h want 34", q); end
    repeat (8) send(16'h5678);
    idle(2);
    n_chk++; if (avg_data !== 16'h5678) begin n_fail++; $display("FAIL coh_avg: got %h want 5678", avg_data); end
    rd(BASE + 22'd1, q);
    n_chk++; if (q !== 8'h12) begin n_fail++; $display("FAIL coh_shadow: got %h want 12", q); end
    rd(BASE, q);
    rd(BASE + 22'd1, q);
    n_chk++; if (q !== 8'h56) begin n_fail++; $display("FAIL coh_shadow2: got %h want 56", q); end
  endtask

  task automatic test_errors();
    logic [7:0] q;
    err_measure = 1'b1;
    idle(3);
    err_measure = 1'b0;
    n_chk++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL ignore_errcnt: got %0d want 4", err_cnt); end
    n_chk++; if (stale !== 1'b0) begin n_fail++; $display("FAIL ignore_stale: got %b want 0", stale); end
    repeat (300) send_err();
    n_chk++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt); end
    n_chk++; if (stale !== 1'b1) begin n_fail++; $display("FAIL sat_stale: got %b want 1", stale); end
    rd(BASE + 22'd2, q);
    n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL reg_errcnt: got %h want ff", q); end
    rd(BASE + 22'd8, q);
    n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL reg_unmapped8: got %h want 00", q); end
    rd(22'h0000FF, q);
    n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL reg_below_base: got %h want 00", q); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] q;
    rd(BASE + 22'd2, q);
    repeat (5) send(16'd7);
    rst_n = 1'b0;
    #1;
    n_chk++; if (avg_data !== 16'd0) begin n_fail++; $display("FAIL mid_avg: got %h want 0", avg_data); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_errcnt: got %0d want 0", err_cnt); end
    n_chk++; if (fx_q !== 8'd0) begin n_fail++; $display("FAIL mid_fxq: got %h want 00", fx_q); end
    n_chk++; if (stale !== 1'b0 || avg_vld !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got stale=%b vld=%b want 0 0", stale, avg_vld); end
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    base = vld_total;
    repeat (8) send(16'd20);
    idle(2);
    n_chk++; if (avg_data !== 16'd20) begin n_fail++; $display("FAIL mid_refill_avg: got %0d want 20", avg_data); end
    n_chk++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL mid_refill_vld: got %0d want 1", vld_total - base); end
  endtask

  task automatic test_minmax();
    logic [7:0] q;
    logic [7:0] exp_v [4];
`ifdef ECHO_MINMAX_EN
    exp_v[0] = 8'h0A; exp_v[1] = 8'h00; exp_v[2] = 8'h46; exp_v[3] = 8'h00;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    send(16'd30);
    send(16'd10);
    send(16'd70);
    idle(1);
`else
    exp_v[0] = 8'h00; exp_v[1] = 8'h00; exp_v[2] = 8'h00; exp_v[3] = 8'h00;
`endif
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 22'(4 + i), q);
      n_chk++;
      if (q !== exp_v[i]) begin
        n_fail++;
        $display("FAIL minmax_reg%0d: got %h want %h", 4 + i, q, exp_v[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    idle(1);
    test_reset();
    test_fill();
    test_run();
    test_stale();
    test_coherent();
    test_errors();
    test_reset_mid();
    test_minmax();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
